// File: rtl/rainbow_pwm_led_pkg.sv
// Shared definitions for the rainbow RGB LED driver.
package rainbow_pwm_led_pkg;

    typedef enum logic [1:0] {
        MODE_RAINBOW = 2'd0,
        MODE_HOLD    = 2'd1,
        MODE_WHITE   = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    localparam int N_SEGS = 6;

    // Active-high {B,G,R} patterns; the top applies pin polarity.
    localparam logic [2:0] LED_DARK  = 3'b000;
    localparam logic [2:0] LED_WHITE = 3'b111;

endpackage

// File: rtl/rainbow_pwm_led_button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter
// and a one-cycle pulse on each accepted press (stable 1->0).
module button_debounce #(
    parameter int CLK_HZ      = 24_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int DB_TICKS = DEBOUNCE_MS * CLK_HZ / 1000;
    localparam int CW       = $clog2(DB_TICKS + 1);

    if (DB_TICKS < 1) begin : g_bad_db
        $error("button_debounce: debounce time is under one clock");
    end

    logic          sync1;
    logic          sync2;
    logic          sync_prev;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
            stable    <= 1'b1;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            sync1     <= btn_n;
            sync2     <= sync1;
            sync_prev <= sync2;
            press     <= 1'b0;
            // Any movement of the synchronised level restarts the wait.
            if (sync2 != sync_prev) begin
                cnt <= '0;
            end else if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_TICKS - 1)) begin
                cnt    <= '0;
                stable <= sync2;
                press  <= stable & ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rainbow_pwm_led.sv
// Rainbow RGB LED driver: hue wheel stepper, per-channel PWM
// and a button-stepped display mode.
module rainbow_pwm_led
    import rainbow_pwm_led_pkg::*;
#(
    parameter int CLK_HZ        = 24_000_000,
    parameter int RAINBOW_MS    = 10_000,
    parameter int PWM_BITS      = 8,
    parameter int STEPS_PER_SEG = 32,
    parameter int DEBOUNCE_MS   = 20,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 button_b,
    output logic [2:0]                           led,
    output logic [1:0]                           mode,
    output logic [$clog2(6*STEPS_PER_SEG)-1:0]   hue
);

    localparam int STEP_TICKS =
        CLK_HZ / 1000 * RAINBOW_MS / (N_SEGS * STEPS_PER_SEG);
    localparam int SB    = $clog2(STEPS_PER_SEG);
    localparam int PW    = $clog2(STEP_TICKS + 1);
    localparam int DW    = PWM_BITS + 1;
    localparam int HUE_W = $clog2(N_SEGS * STEPS_PER_SEG);
    localparam logic [DW-1:0] FULL = {1'b1, {PWM_BITS{1'b0}}};

    if (STEP_TICKS == 0) begin : g_bad_ticks
        $error("rainbow_pwm_led: STEP_TICKS evaluates to 0");
    end
    if (STEPS_PER_SEG < 2 || (1 << SB) != STEPS_PER_SEG
        || SB > PWM_BITS) begin : g_bad_steps
        $error("rainbow_pwm_led: bad STEPS_PER_SEG");
    end

    mode_t               mode_q;
    logic [PW-1:0]       presc;
    logic [2:0]          seg;
    logic [SB-1:0]       step;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DW-1:0]       lvl;
    logic [DW-1:0]       duty_r;
    logic [DW-1:0]       duty_g;
    logic [DW-1:0]       duty_b;
    logic [2:0]          lit;
    logic                step_tick;
    logic                press;

    button_debounce #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (button_b),
        .press (press)
    );

    assign step_tick = (mode_q == MODE_RAINBOW)
                    && (presc == PW'(STEP_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_RAINBOW;
            presc   <= '0;
            seg     <= 3'd0;
            step    <= '0;
            pwm_cnt <= '0;
            led     <= (ACTIVE_LOW != 0) ? ~LED_DARK : LED_DARK;
        end else begin
            // Held at zero outside RAINBOW so a resume waits a full step.
            if (mode_q != MODE_RAINBOW || step_tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            if (step_tick) begin
                if (&step) begin
                    step <= '0;
                    seg  <= (seg == 3'(N_SEGS - 1)) ? 3'd0 : seg + 3'd1;
                end else begin
                    step <= step + 1'b1;
                end
            end
            pwm_cnt <= pwm_cnt + 1'b1;
            if (press) begin
                mode_q <= mode_t'(mode_q + 2'd1);
            end
            led <= (ACTIVE_LOW != 0) ? ~lit : lit;
        end
    end

    always_comb begin
        lvl    = DW'(step) << (PWM_BITS - SB);
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        case (seg)
            3'd0: begin
                duty_r = FULL;
                duty_g = lvl;
            end
            3'd1: begin
                duty_r = FULL - lvl;
                duty_g = FULL;
            end
            3'd2: begin
                duty_g = FULL;
                duty_b = lvl;
            end
            3'd3: begin
                duty_g = FULL - lvl;
                duty_b = FULL;
            end
            3'd4: begin
                duty_r = lvl;
                duty_b = FULL;
            end
            3'd5: begin
                duty_r = FULL;
                duty_b = FULL - lvl;
            end
            default: ;
        endcase
        unique case (mode_q)
            MODE_WHITE: begin
                duty_r = FULL;
                duty_g = FULL;
                duty_b = FULL;
            end
            MODE_OFF: begin
                duty_r = '0;
                duty_g = '0;
                duty_b = '0;
            end
            default: ;
        endcase
        lit = {({1'b0, pwm_cnt} < duty_b),
               ({1'b0, pwm_cnt} < duty_g),
               ({1'b0, pwm_cnt} < duty_r)};
    end

    assign mode = mode_q;
    assign hue  = HUE_W'({seg, step});

endmodule

// File: tb/tb_rainbow_pwm_led.sv
// Scoreboard bench for rainbow_pwm_led, with an active-low and
// an active-high instance driven in lockstep.
module tb_rainbow_pwm_led;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       button_b = 1'b1;
    logic [2:0] led;
    logic [2:0] led0;
    logic [1:0] mode;
    logic [1:0] mode0;
    logic [4:0] hue;
    logic [4:0] hue0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string tag;
        int    exp;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    rainbow_pwm_led #(
        .CLK_HZ(48_000), .RAINBOW_MS(1000), .PWM_BITS(4),
        .STEPS_PER_SEG(4), .DEBOUNCE_MS(1), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button_b(button_b),
        .led(led), .mode(mode), .hue(hue)
    );

    rainbow_pwm_led #(
        .CLK_HZ(48_000), .RAINBOW_MS(1000), .PWM_BITS(4),
        .STEPS_PER_SEG(4), .DEBOUNCE_MS(1), .ACTIVE_LOW(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .button_b(button_b),
        .led(led0), .mode(mode0), .hue(hue0)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        sb_q.push_back('{tag, exp});
    endtask

    task automatic sb_pop(input int obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: got %0d, want queued entry", obs);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    // Lit cycles per 16-cycle PWM period for each channel.
    function automatic void model(input int h, input int md,
                                  output int r, output int g,
                                  output int b);
        int s;
        int l;
        s = h / 4;
        l = (h % 4) * 4;
        r = 0;
        g = 0;
        b = 0;
        case (s)
            0: begin r = 16;     g = l;      end
            1: begin r = 16 - l; g = 16;     end
            2: begin g = 16;     b = l;      end
            3: begin g = 16 - l; b = 16;     end
            4: begin r = l;      b = 16;     end
            default: begin r = 16; b = 16 - l; end
        endcase
        if (md == 2) begin r = 16; g = 16; b = 16; end
        if (md == 3) begin r = 0;  g = 0;  b = 0;  end
    endfunction

    task automatic pwm_check(input string tag, input int h, input int md);
        int er, eg, eb;
        int r, g, b, r0, g0, b0;
        model(h, md, er, eg, eb);
        sb_push({tag, "_r"}, er);
        sb_push({tag, "_g"}, eg);
        sb_push({tag, "_b"}, eb);
        sb_push({tag, "_r0"}, er);
        sb_push({tag, "_g0"}, eg);
        sb_push({tag, "_b0"}, eb);
        r = 0; g = 0; b = 0; r0 = 0; g0 = 0; b0 = 0;
        repeat (16) begin
            @(negedge clk);
            r  += int'(!led[0]);
            g  += int'(!led[1]);
            b  += int'(!led[2]);
            r0 += int'(led0[0]);
            g0 += int'(led0[1]);
            b0 += int'(led0[2]);
        end
        sb_pop(r);
        sb_pop(g);
        sb_pop(b);
        sb_pop(r0);
        sb_pop(g0);
        sb_pop(b0);
    endtask

    task automatic wait_hue_change(input int from, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(hue) == from && n < 2100);
    endtask

    task automatic press_to(input int target);
        int n;
        n = 0;
        button_b = 1'b0;
        sb_push("press_mode", target);
        while (int'(mode) != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        sb_pop(mode);
        button_b = 1'b1;
    endtask

    initial begin
        int n;
        int cur;

        // Reset values while rst_n is low
        #1 rst_n = 1'b0;
        #1;
        sb_push("rst_led", 7);
        sb_push("rst_led0", 0);
        sb_push("rst_mode", 0);
        sb_push("rst_hue", 0);
        sb_pop(led);
        sb_pop(led0);
        sb_pop(mode);
        sb_pop(hue);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        pwm_check("rst_pwm", 0, 0);

        // Debounce: bounces, a real press, then a short glitch
        for (int i = 0; i < 4; i++) begin
            button_b = 1'b0;
            repeat (10) @(negedge clk);
            button_b = 1'b1;
            repeat (10) @(negedge clk);
        end
        sb_push("bounce", 0);
        sb_pop(mode);
        button_b = 1'b0;
        repeat (100) @(negedge clk);
        sb_push("hold_press", 1);
        sb_pop(mode);
        button_b = 1'b1;
        repeat (100) @(negedge clk);
        sb_push("release", 1);
        sb_pop(mode);
        button_b = 1'b0;
        repeat (40) @(negedge clk);
        button_b = 1'b1;
        repeat (100) @(negedge clk);
        sb_push("glitch", 1);
        sb_pop(mode);

        // HOLD, WHITE, OFF, back to RAINBOW
        repeat (10000) @(negedge clk);
        sb_push("hold_hue", 0);
        sb_pop(hue);
        pwm_check("hold_pwm", 0, 1);
        press_to(2);
        pwm_check("white", 0, 2);
        sb_push("white_hue", 0);
        sb_pop(hue);
        repeat (100) @(negedge clk);
        press_to(3);
        pwm_check("off", 0, 3);
        sb_push("off_hue", 0);
        sb_pop(hue);
        repeat (100) @(negedge clk);
        press_to(0);
        sb_push("resume_len", 2000);
        sb_push("resume_hue", 1);
        wait_hue_change(0, n);
        sb_pop(n);
        sb_pop(hue);

        // Full hue wheel with PWM duty per hue
        cur = 1;
        for (int i = 0; i < 24; i++) begin
            pwm_check($sformatf("sweep_h%0d", cur), cur, 0);
            sb_push($sformatf("step_len_h%0d", cur), 2000);
            sb_push($sformatf("hue_after_h%0d", cur), (cur + 1) % 24);
            wait_hue_change(cur, n);
            sb_pop(n + 16);
            sb_pop(hue);
            cur = (cur + 1) % 24;
        end

        // Async reset from WHITE with a non-zero hue
        press_to(1);
        repeat (100) @(negedge clk);
        press_to(2);
        repeat (20) @(negedge clk);
        sb_push("pre_rst_hue", 1);
        sb_pop(hue);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb_push("arst_led", 7);
        sb_push("arst_led0", 0);
        sb_push("arst_mode", 0);
        sb_push("arst_mode0", 0);
        sb_push("arst_hue", 0);
        sb_push("arst_hue0", 0);
        sb_pop(led);
        sb_pop(led0);
        sb_pop(mode);
        sb_pop(mode0);
        sb_pop(hue);
        sb_pop(hue0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries, want 0",
                     sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
